// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Sequencing controller for the 5-stage MIPS core (no forwarding).
// Owns the PC load enable, the IF/ID load enable and the flushes of the
// three pipeline registers BF0..BF2. Stalls fetch on RAW hazards against
// EX/MEM/WB, squashes the wrong path when a branch/jump resolves in MEM,
// sequences HALT / RUN / STEP and keeps saturating stall/flush counters.
//
// Ports
//   clk_PCTRL, rst_PCTRL        clock, asynchronous active-high reset
//   run_en, halt_req            level controls (halt_req has priority)
//   step_req, step_count        one-cycle pulse plus fetch count for STEP
//   id_rs, id_rt                sources of the instruction in ID
//   ex/mem/wb_rd, *_regwrite    destinations and RegWrite of later stages
//   branch_taken, jump_taken    redirect requests resolved in MEM
//   pc_we, bf0_we               PC / IF-ID load enables (combinational)
//   bf0/1/2_flush               zero the stage on the next edge (comb.)
//   pc_sel_redirect             PC loads the branch/jump target (comb.)
//   halted, state, step_left    registered sequencing state
//   stall_cnt, flush_cnt        registered saturating event counters
module pipeline_ctrl #(
    parameter int REG_W  = 5,
    parameter int STEP_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_PCTRL,
    input  logic              rst_PCTRL,
    input  logic              run_en,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              branch_taken,
    input  logic              jump_taken,
    output logic              pc_we,
    output logic              bf0_we,
    output logic              bf0_flush,
    output logic              bf1_flush,
    output logic              bf2_flush,
    output logic              pc_sel_redirect,
    output logic              halted,
    output logic [1:0]        state,
    output logic [STEP_W-1:0] step_left,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic              halted_q, halted_d;
    logic [STEP_W-1:0] step_left_q, step_left_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic rs_hit, rt_hit, hazard, redirect, active, advance, stall_ev;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    always_comb begin
        rs_hit = (id_rs != '0) &&
                 ((ex_regwrite  && (ex_rd  == id_rs)) ||
                  (mem_regwrite && (mem_rd == id_rs)) ||
                  (wb_regwrite  && (wb_rd  == id_rs)));
        rt_hit = (id_rt != '0) &&
                 ((ex_regwrite  && (ex_rd  == id_rt)) ||
                  (mem_regwrite && (mem_rd == id_rt)) ||
                  (wb_regwrite  && (wb_rd  == id_rt)));
    end

    assign hazard   = rs_hit | rt_hit;
    assign redirect = branch_taken | jump_taken;
    assign active   = (state_q != ST_HALT);
    // Redirect wins over a stall: the stalled instruction is wrong-path anyway.
    assign advance  = active && !redirect && !hazard;
    assign stall_ev = active && !redirect && hazard;

    // Pipeline gating. Stalls and HALT both hold PC/IF-ID and inject a
    // bubble into ID/EX; the older stages keep flowing so producers drain.
    always_comb begin
        pc_we           = 1'b0;
        bf0_we          = 1'b0;
        bf0_flush       = 1'b0;
        bf1_flush       = 1'b0;
        bf2_flush       = 1'b0;
        pc_sel_redirect = 1'b0;
        if (rst_PCTRL) begin
            bf0_flush = 1'b1;
            bf1_flush = 1'b1;
            bf2_flush = 1'b1;
        end else if (redirect) begin
            pc_we           = 1'b1;
            bf0_we          = 1'b1;
            pc_sel_redirect = 1'b1;
            bf0_flush       = 1'b1;
            bf1_flush       = 1'b1;
            bf2_flush       = 1'b1;
        end else if (!active || hazard) begin
            bf1_flush = 1'b1;
        end else begin
            pc_we  = 1'b1;
            bf0_we = 1'b1;
        end
    end

    // Sequencing. Transitions land on the edge after the request, so the
    // cycle carrying halt_req still behaves as its current state.
    always_comb begin
        state_d     = state_q;
        step_left_d = step_left_q;
        case (state_q)
            ST_HALT: begin
                if (!halt_req) begin
                    if (run_en) begin
                        state_d = ST_RUN;
                    end else if (step_req && (step_count != '0)) begin
                        state_d     = ST_STEP;
                        step_left_d = step_count;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req) state_d = ST_HALT;
            end
            ST_STEP: begin
                // Only real fetches consume the budget; stalls and
                // redirect cycles do not.
                if (halt_req) begin
                    state_d     = ST_HALT;
                    step_left_d = '0;
                end else if (advance) begin
                    if (step_left_q == STEP_ONE) begin
                        state_d     = ST_HALT;
                        step_left_d = '0;
                    end else begin
                        step_left_d = step_left_q - STEP_ONE;
                    end
                end
            end
            default: begin
                state_d     = ST_HALT;
                step_left_d = '0;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ev && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (redirect && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk_PCTRL or posedge rst_PCTRL) begin
        if (rst_PCTRL) begin
            state_q     <= ST_HALT;
            halted_q    <= 1'b1;
            step_left_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            step_left_q <= step_left_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign halted    = halted_q;
    assign step_left = step_left_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl. Each cycle the driver applies
// inputs and queues the hand-computed response; a monitor on the falling
// edge pops and compares. A second instance with 4-bit counters shares the
// stimulus so counter saturation is reachable in a short run.
module tb_pipeline_ctrl;

    localparam logic [5:0] ADV  = 6'b110000; // {pc_we,bf0_we,f0,f1,f2,sel}
    localparam logic [5:0] STL  = 6'b000100;
    localparam logic [5:0] HLT  = 6'b000100;
    localparam logic [5:0] RDR  = 6'b111111;
    localparam logic [5:0] RSTO = 6'b001110;
    localparam logic [1:0] H = 2'd0, R = 2'd1, S = 2'd2;

    logic clk = 1'b0;
    logic rst;
    logic run_en, halt_req, step_req, ex_w, mem_w, wb_w, br, jp;
    logic [7:0] step_count;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;

    logic pc_we, bf0_we, bf0_flush, bf1_flush, bf2_flush, pc_sel_redirect, halted;
    logic [1:0] state;
    logic [7:0] step_left;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_pc_we, s_bf0_we, s_f0, s_f1, s_f2, s_sel, s_halted;
    logic [1:0] s_state;
    logic [7:0] s_left;
    logic [3:0] s_stall, s_flush;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_W(5), .STEP_W(8), .CNT_W(16)) dut (
        .clk_PCTRL(clk), .rst_PCTRL(rst), .run_en(run_en), .halt_req(halt_req),
        .step_req(step_req), .step_count(step_count), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_regwrite(ex_w),
        .mem_regwrite(mem_w), .wb_regwrite(wb_w), .branch_taken(br), .jump_taken(jp),
        .pc_we(pc_we), .bf0_we(bf0_we), .bf0_flush(bf0_flush), .bf1_flush(bf1_flush),
        .bf2_flush(bf2_flush), .pc_sel_redirect(pc_sel_redirect), .halted(halted),
        .state(state), .step_left(step_left), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.REG_W(5), .STEP_W(8), .CNT_W(4)) dut_sat (
        .clk_PCTRL(clk), .rst_PCTRL(rst), .run_en(run_en), .halt_req(halt_req),
        .step_req(step_req), .step_count(step_count), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_regwrite(ex_w),
        .mem_regwrite(mem_w), .wb_regwrite(wb_w), .branch_taken(br), .jump_taken(jp),
        .pc_we(s_pc_we), .bf0_we(s_bf0_we), .bf0_flush(s_f0), .bf1_flush(s_f1),
        .bf2_flush(s_f2), .pc_sel_redirect(s_sel), .halted(s_halted),
        .state(s_state), .step_left(s_left), .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    typedef struct packed {
        logic [5:0]  o;
        logic [1:0]  st;
        logic        hl;
        logic [7:0]  left;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  ssc;
        logic [3:0]  sfc;
    } obs_t;

    typedef struct {
        int   id;
        obs_t v;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    obs_t got;
    int checks = 0, errors = 0, vid = 0;

    assign got = {pc_we, bf0_we, bf0_flush, bf1_flush, bf2_flush, pc_sel_redirect,
                  state, halted, step_left, stall_cnt, flush_cnt, s_stall, s_flush};

    function automatic logic [3:0] sat4(input logic [15:0] x);
        return (x > 16'd15) ? 4'hF : x[3:0];
    endfunction

    task automatic clr();
        run_en = 0; halt_req = 0; step_req = 0; step_count = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_w = 0; mem_w = 0; wb_w = 0; br = 0; jp = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1; clr();
    endtask

    task automatic ex(input logic [5:0] o, input logic [1:0] st, input logic [7:0] left,
                      input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.id = vid; vid++;
        e.v.o = o; e.v.st = st; e.v.hl = (st == H); e.v.left = left;
        e.v.sc = sc; e.v.fc = fc; e.v.ssc = sat4(sc); e.v.sfc = sat4(fc);
        q.push_back(e);
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            cur = q.pop_front();
            checks++;
            if (got !== cur.v) begin
                errors++;
                $display("FAIL vec%0d: got o=%b st=%0d hl=%b left=%0d stall=%0d flush=%0d sat=%0d/%0d, want o=%b st=%0d hl=%b left=%0d stall=%0d flush=%0d sat=%0d/%0d",
                         cur.id, got.o, got.st, got.hl, got.left, got.sc, got.fc, got.ssc, got.sfc,
                         cur.v.o, cur.v.st, cur.v.hl, cur.v.left, cur.v.sc, cur.v.fc, cur.v.ssc, cur.v.sfc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; clr();
        // reset values
        cyc(); ex(RSTO, H, 0, 0, 0);
        cyc(); ex(RSTO, H, 0, 0, 0);
        cyc(); rst = 0; ex(HLT, H, 0, 0, 0);
        // HALT -> RUN, free-running fetch
        cyc(); run_en = 1; ex(HLT, H, 0, 0, 0);
        cyc(); ex(ADV, R, 0, 0, 0);
        cyc(); ex(ADV, R, 0, 0, 0);
        // EX producer drains EX -> MEM -> WB: three stall cycles
        cyc(); id_rs = 5; ex_rd = 5; ex_w = 1; ex(STL, R, 0, 0, 0);
        cyc(); id_rs = 5; mem_rd = 5; mem_w = 1; ex(STL, R, 0, 1, 0);
        cyc(); id_rs = 5; wb_rd = 5; wb_w = 1; ex(STL, R, 0, 2, 0);
        cyc(); id_rs = 5; ex(ADV, R, 0, 3, 0);
        // $zero never hazards; RegWrite=0 never hazards; rt path does
        cyc(); ex_rd = 0; ex_w = 1; ex(ADV, R, 0, 3, 0);
        cyc(); id_rt = 9; wb_rd = 9; ex(ADV, R, 0, 3, 0);
        cyc(); id_rt = 9; wb_rd = 9; wb_w = 1; ex(STL, R, 0, 3, 0);
        // redirect beats a coincident hazard
        cyc(); br = 1; id_rs = 5; ex_rd = 5; ex_w = 1; ex(RDR, R, 0, 4, 0);
        cyc(); jp = 1; ex(RDR, R, 0, 4, 1);
        // halt: request cycle still runs
        cyc(); halt_req = 1; ex(ADV, R, 0, 4, 2);
        cyc(); id_rs = 5; ex_rd = 5; ex_w = 1; ex(HLT, H, 0, 4, 2);
        cyc(); br = 1; ex(RDR, H, 0, 4, 2);
        // step of 4 with a hazard in the middle
        cyc(); step_req = 1; step_count = 4; ex(HLT, H, 0, 4, 3);
        cyc(); ex(ADV, S, 4, 4, 3);
        cyc(); ex(ADV, S, 3, 4, 3);
        cyc(); id_rs = 5; ex_rd = 5; ex_w = 1; ex(STL, S, 2, 4, 3);
        cyc(); ex(ADV, S, 2, 5, 3);
        cyc(); ex(ADV, S, 1, 5, 3);
        cyc(); ex(HLT, H, 0, 5, 3);
        // run_en ignored in STEP; halt at step_left=2 clears it
        cyc(); step_req = 1; step_count = 3; ex(HLT, H, 0, 5, 3);
        cyc(); run_en = 1; ex(ADV, S, 3, 5, 3);
        cyc(); halt_req = 1; ex(ADV, S, 2, 5, 3);
        cyc(); step_req = 1; step_count = 0; ex(HLT, H, 0, 5, 3);
        cyc(); ex(HLT, H, 0, 5, 3);
        cyc(); halt_req = 1; step_req = 1; step_count = 2; ex(HLT, H, 0, 5, 3);
        cyc(); ex(HLT, H, 0, 5, 3);
        // redirect cycles in STEP do not consume the budget
        cyc(); step_req = 1; step_count = 2; ex(HLT, H, 0, 5, 3);
        cyc(); jp = 1; ex(RDR, S, 2, 5, 3);
        cyc(); ex(ADV, S, 2, 5, 4);
        cyc(); ex(ADV, S, 1, 5, 4);
        cyc(); ex(HLT, H, 0, 5, 4);
        // drive counters past the 4-bit instance's all-ones
        cyc(); run_en = 1; ex(HLT, H, 0, 5, 4);
        for (int i = 0; i < 20; i++) begin
            cyc(); id_rt = 3; mem_rd = 3; mem_w = 1; ex(STL, R, 0, 16'(5 + i), 4);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(); br = 1; ex(RDR, R, 0, 25, 16'(4 + i));
        end
        cyc(); ex(ADV, R, 0, 25, 24);
        // async reset mid-RUN
        cyc(); rst = 1; ex(RSTO, H, 0, 0, 0);
        cyc(); rst = 0; ex(HLT, H, 0, 0, 0);
        // reset mid-STEP aborts the step
        cyc(); step_req = 1; step_count = 5; ex(HLT, H, 0, 0, 0);
        cyc(); ex(ADV, S, 5, 0, 0);
        cyc(); rst = 1; ex(RSTO, H, 0, 0, 0);
        cyc(); rst = 0; ex(HLT, H, 0, 0, 0);
        cyc(); ex(HLT, H, 0, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
